bus_err_irq_agg: RTL and testbench

BUS_ERR_IRQ_AGG -- requirements
Module: bus_err_irq_agg

---
 rtl/bus_err_irq_agg.sv | 189 ++++++++++++++++++
 tb/tb_bus_err_irq_agg.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_err_irq_agg.sv
// Bus error interrupt aggregator: per-source edge latching and event counting,
// combined into one throttled interrupt with a programmable holdoff window.

package bus_err_irq_agg_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

// One error source: rising-edge detect, sticky pending bit, saturating counter.
module bus_err_irq_agg_lane #(
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                err_i,
  input  logic                clr_pend_i,
  input  logic                clr_cnt_i,
  output logic                pend_o,
  output logic [CntWidth-1:0] cnt_o
);
  logic prev_q;
  logic edge_w;

  assign edge_w = err_i & ~prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
      pend_o <= 1'b0;
      cnt_o  <= '0;
    end else begin
      prev_q <= err_i;
      // A new edge beats a simultaneous software clear so no event is lost.
      if (edge_w)          pend_o <= 1'b1;
      else if (clr_pend_i) pend_o <= 1'b0;
      if (clr_cnt_i)                  cnt_o <= edge_w ? CntWidth'(1) : '0;
      else if (edge_w && cnt_o != '1) cnt_o <= cnt_o + CntWidth'(1);
    end
  end
endmodule

module bus_err_irq_agg #(
  parameter int          NumSources   = 2,
  parameter int          CntWidth     = 16,
  parameter logic [15:0] HoldoffReset = 16'd0,
  parameter type         reg_req_t    = bus_err_irq_agg_pkg::reg_req_t,
  parameter type         reg_rsp_t    = bus_err_irq_agg_pkg::reg_rsp_t
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumSources-1:0] err_irq_i,
  output logic                  irq_o,
  input  reg_req_t              reg_req_i,
  output reg_rsp_t              reg_rsp_o
);
  typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;

  state_t                               state_q;
  logic [15:0]                          timer_q;
  logic [15:0]                          holdoff_q;
  logic [NumSources-1:0]                enable_q;
  logic [NumSources-1:0]                pending;
  logic [NumSources-1:0][CntWidth-1:0]  cnt;
  logic [NumSources-1:0]                clr_pend;
  logic [NumSources-1:0]                clr_cnt;
  logic [2:0]                           idx;
  logic                                 dec_err;
  logic                                 wr;
  logic [31:0]                          rdata;
  logic                                 cause;

  assign idx   = reg_req_i.addr[4:2];
  assign cause = |(pending & enable_q);

  // Address decode and read mux; bad addresses read zero and never write.
  always_comb begin
    rdata   = '0;
    dec_err = 1'b0;
    case (idx)
      3'd0: rdata[NumSources-1:0] = pending;
      3'd1: rdata[NumSources-1:0] = enable_q;
      3'd2: rdata[15:0]           = holdoff_q;
      3'd3: dec_err               = 1'b1;
      default: begin
        dec_err = 1'b1;
        for (int i = 0; i < NumSources; i++) begin
          if (idx == 3'(4 + i)) begin
            dec_err              = 1'b0;
            rdata[CntWidth-1:0]  = cnt[i];
          end
        end
      end
    endcase
  end

  assign wr = reg_req_i.valid & reg_req_i.write & ~dec_err;

  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = 1'b1;
    reg_rsp_o.error = reg_req_i.valid & dec_err;
    reg_rsp_o.rdata = (reg_req_i.valid && !dec_err) ? rdata : 32'd0;
  end

  always_comb begin
    clr_pend = (wr && idx == 3'd0) ? reg_req_i.wdata[NumSources-1:0] : '0;
    clr_cnt  = '0;
    for (int i = 0; i < NumSources; i++)
      clr_cnt[i] = wr && (idx == 3'(4 + i));
  end

  for (genvar g = 0; g < NumSources; g++) begin : g_lane
    bus_err_irq_agg_lane #(.CntWidth(CntWidth)) u_lane (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .err_i      (err_irq_i[g]),
      .clr_pend_i (clr_pend[g]),
      .clr_cnt_i  (clr_cnt[g]),
      .pend_o     (pending[g]),
      .cnt_o      (cnt[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable_q  <= '0;
      holdoff_q <= HoldoffReset;
    end else if (wr) begin
      if (idx == 3'd1) enable_q  <= reg_req_i.wdata[NumSources-1:0];
      if (idx == 3'd2) holdoff_q <= reg_req_i.wdata[15:0];
    end
  end

  // irq_o is the registered image of the ASSERT state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      timer_q <= '0;
      irq_o   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cause) begin
            state_q <= ASSERT;
            irq_o   <= 1'b1;
          end
        end
        ASSERT: begin
          if (!cause) begin
            irq_o <= 1'b0;
            if (holdoff_q == 16'd0) begin
              state_q <= IDLE;
            end else begin
              state_q <= HOLDOFF;
              timer_q <= holdoff_q;
            end
          end
        end
        HOLDOFF: begin
          if (timer_q == 16'd1) begin
            state_q <= IDLE;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          irq_o   <= 1'b0;
        end
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{reg_req_i.addr[31:5], reg_req_i.addr[1:0],
                         reg_req_i.wstrb, reg_req_i.wdata[31:16]};
endmodule

// File: tb/tb_bus_err_irq_agg.sv
// Scenario bench for bus_err_irq_agg: expected values are queued when stimulus
// is applied and popped when the matching DUT output is sampled.
module tb_bus_err_irq_agg;
  import bus_err_irq_agg_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  logic [1:0] err_irq;
  logic     irq;
  reg_req_t req;
  reg_rsp_t rsp;
  logic     err2;
  logic     irq2;
  reg_req_t req2;
  reg_rsp_t rsp2;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int cnt0 = 0;
  int cnt1 = 0;

  always #5 clk = ~clk;

  bus_err_irq_agg #(.NumSources(2), .CntWidth(16), .HoldoffReset(16'd3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .err_irq_i(err_irq), .irq_o(irq),
    .reg_req_i(req), .reg_rsp_o(rsp));

  bus_err_irq_agg #(.NumSources(1), .CntWidth(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .err_irq_i(err2), .irq_o(irq2),
    .reg_req_i(req2), .reg_rsp_o(rsp2));

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_rd(input bit sel, input logic [31:0] a,
                        output logic [31:0] d, output logic e, output logic r);
    if (sel) begin req2 = '0; req2.addr = a; req2.valid = 1'b1; end
    else     begin req  = '0; req.addr  = a; req.valid  = 1'b1; end
    #2;
    d = sel ? rsp2.rdata : rsp.rdata;
    e = sel ? rsp2.error : rsp.error;
    r = sel ? rsp2.ready : rsp.ready;
    tick();
    req = '0; req2 = '0;
  endtask

  task automatic bus_wr(input bit sel, input logic [31:0] a, input logic [31:0] d);
    if (sel) begin req2 = '0; req2.addr = a; req2.wdata = d; req2.write = 1'b1; req2.wstrb = 4'hf; req2.valid = 1'b1; end
    else     begin req  = '0; req.addr  = a; req.wdata  = d; req.write  = 1'b1; req.wstrb  = 4'hf; req.valid  = 1'b1; end
    tick();
    req = '0; req2 = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    logic er, rd;
    logic [31:0] addrs [5] = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14};
    #12;
    exp_q.push_back(0); e = pop_exp(); checks++;
    if (irq !== e[0]) begin errors++; $display("FAIL reset_irq_in_reset got %0b want %0b", irq, e[0]); end
    #5 rst_n = 1'b1;
    tick();
    foreach (addrs[k]) begin
      exp_q.push_back((addrs[k] == 32'h08) ? 32'd3 : 32'd0);
      bus_rd(0, addrs[k], d, er, rd);
      e = pop_exp(); checks++;
      if (d !== e) begin errors++; $display("FAIL reset_reg_%0h got %0h want %0h", addrs[k], d, e); end
    end
    exp_q.push_back(0); e = pop_exp(); checks++;
    if (irq !== e[0]) begin errors++; $display("FAIL reset_irq got %0b want %0b", irq, e[0]); end
  endtask

  task automatic test_basic();
    logic [31:0] d, e;
    logic er, rd;
    bus_wr(0, 32'h04, 32'h3);
    bus_wr(0, 32'h08, 32'h0);
    err_irq[0] = 1'b1; cnt0++;
    exp_q.push_back(0); e = pop_exp(); checks++;
    if (irq !== e[0]) begin errors++; $display("FAIL basic_irq_n got %0b want %0b", irq, e[0]); end
    tick();
    exp_q.push_back(1);
    exp_q.push_back(0);
    bus_rd(0, 32'h00, d, er, rd);
    e = pop_exp(); checks++;
    if (d !== e) begin errors++; $display("FAIL basic_pending_n1 got %0h want %0h", d, e); end
    e = pop_exp(); checks++;
    // bus_rd consumed cycle N+1; irq sampled now belongs to N+2
    exp_q.push_back(1);
    e = pop_exp(); checks++;
    if (irq !== e[0]) begin errors++; $display("FAIL basic_irq_n2 got %0b want %0b", irq, e[0]); end
    err_irq[0] = 1'b0;
    bus_wr(0, 32'h00, 32'h1);
    exp_q.push_back(1); e = pop_exp(); checks++;
    if (irq !== e[0]) begin errors++; $display("FAIL basic_irq_clr1 got %0b want %0b", irq, e[0]); end
    tick();
    exp_q.push_back(0); e = pop_exp(); checks++;
    if (irq !== e[0]) begin errors++; $display("FAIL basic_irq_clr2 got %0b want %0b", irq, e[0]); end
    exp_q.push_back(cnt0);
    bus_rd(0, 32'h10, d, er, rd);
    e = pop_exp(); checks++;
    if (d !== e) begin errors++; $display("FAIL basic_count0 got %0d want %0d", d, e); end
  endtask

  task automatic test_holdoff();
    logic [31:0] d, e;
    logic er, rd;
    logic [7:0] seq1 = 8'b1000_0001;
    logic [4:0] seq2 = 5'b10001;
    bus_wr(0, 32'h08, 32'd5);
    err_irq[1] = 1'b1; cnt1++;
    tick(); err_irq[1] = 1'b0;
    tick();
    exp_q.push_back(1); e = pop_exp(); checks++;
    if (irq !== e[0]) begin errors++; $display("FAIL hold_irq_assert got %0b want %0b", irq, e[0]); end
    bus_wr(0, 32'h00, 32'h2);
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) begin err_irq[0] = 1'b1; cnt0++; end
      if (c == 4) begin
        err_irq[0] = 1'b0;
        req = '0; req.addr = 32'h08; req.wdata = 32'd2; req.write = 1'b1; req.valid = 1'b1;
      end
      if (c == 5) req = '0;
      exp_q.push_back({31'd0, seq1[c-1]});
      e = pop_exp(); checks++;
      if (irq !== e[0]) begin errors++; $display("FAIL hold5_irq_c%0d got %0b want %0b", c, irq, e[0]); end
      tick();
    end
    bus_wr(0, 32'h00, 32'h1);
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin err_irq[1] = 1'b1; cnt1++; end
      if (c == 3) err_irq[1] = 1'b0;
      exp_q.push_back({31'd0, seq2[c-1]});
      e = pop_exp(); checks++;
      if (irq !== e[0]) begin errors++; $display("FAIL hold2_irq_c%0d got %0b want %0b", c, irq, e[0]); end
      tick();
    end
    bus_wr(0, 32'h08, 32'd0);
    bus_wr(0, 32'h00, 32'h3);
    tick();
    exp_q.push_back(0); e = pop_exp(); checks++;
    if (irq !== e[0]) begin errors++; $display("FAIL hold_irq_cleanup got %0b want %0b", irq, e[0]); end
  endtask

  task automatic test_enable_clear();
    logic [31:0] d, e;
    logic er, rd;
    err_irq[0] = 1'b1; cnt0++;
    tick(); err_irq[0] = 1'b0;
    tick();
    exp_q.push_back(1); e = pop_exp(); checks++;
    if (irq !== e[0]) begin errors++; $display("FAIL en_irq_assert got %0b want %0b", irq, e[0]); end
    bus_wr(0, 32'h04, 32'h0);
    exp_q.push_back(1); e = pop_exp(); checks++;
    if (irq !== e[0]) begin errors++; $display("FAIL en_irq_e1 got %0b want %0b", irq, e[0]); end
    tick();
    exp_q.push_back(0); e = pop_exp(); checks++;
    if (irq !== e[0]) begin errors++; $display("FAIL en_irq_e2 got %0b want %0b", irq, e[0]); end
    exp_q.push_back(1);
    bus_rd(0, 32'h00, d, er, rd);
    e = pop_exp(); checks++;
    if (d !== e) begin errors++; $display("FAIL en_pending_kept got %0h want %0h", d, e); end
    bus_wr(0, 32'h04, 32'h3);
    exp_q.push_back(0); e = pop_exp(); checks++;
    if (irq !== e[0]) begin errors++; $display("FAIL en_irq_f1 got %0b want %0b", irq, e[0]); end
    tick();
    exp_q.push_back(1); e = pop_exp(); checks++;
    if (irq !== e[0]) begin errors++; $display("FAIL en_irq_f2 got %0b want %0b", irq, e[0]); end
    bus_wr(0, 32'h00, 32'h1);
    tick();
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d, e;
    logic er, rd;
    err_irq[1] = 1'b1; cnt1++;
    tick(); err_irq[1] = 1'b0;
    tick();
    exp_q.push_back(1); e = pop_exp(); checks++;
    if (irq !== e[0]) begin errors++; $display("FAIL w1c_irq_assert got %0b want %0b", irq, e[0]); end
    err_irq[1] = 1'b1; cnt1++;
    bus_wr(0, 32'h00, 32'h2);
    err_irq[1] = 1'b0;
    exp_q.push_back(1); e = pop_exp(); checks++;
    if (irq !== e[0]) begin errors++; $display("FAIL w1c_irq_b1 got %0b want %0b", irq, e[0]); end
    exp_q.push_back(2);
    bus_rd(0, 32'h00, d, er, rd);
    e = pop_exp(); checks++;
    if (d !== e) begin errors++; $display("FAIL w1c_pending_set_wins got %0h want %0h", d, e); end
    exp_q.push_back(1); e = pop_exp(); checks++;
    if (irq !== e[0]) begin errors++; $display("FAIL w1c_irq_b2 got %0b want %0b", irq, e[0]); end
    exp_q.push_back(cnt1);
    bus_rd(0, 32'h14, d, er, rd);
    e = pop_exp(); checks++;
    if (d !== e) begin errors++; $display("FAIL w1c_count1 got %0d want %0d", d, e); end
    bus_wr(0, 32'h00, 32'h2);
    tick();
    exp_q.push_back(0); e = pop_exp(); checks++;
    if (irq !== e[0]) begin errors++; $display("FAIL w1c_irq_clear got %0b want %0b", irq, e[0]); end
  endtask

  task automatic test_count_clear();
    logic [31:0] d, e;
    logic er, rd;
    bus_wr(0, 32'h14, 32'hdeadbeef); cnt1 = 0;
    exp_q.push_back(cnt1);
    exp_q.push_back(cnt0);
    bus_rd(0, 32'h14, d, er, rd);
    e = pop_exp(); checks++;
    if (d !== e) begin errors++; $display("FAIL cnt_clear1 got %0d want %0d", d, e); end
    bus_rd(0, 32'h10, d, er, rd);
    e = pop_exp(); checks++;
    if (d !== e) begin errors++; $display("FAIL cnt_keep0 got %0d want %0d", d, e); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d, e;
    logic er, rd;
    logic [31:0] addrs [3] = '{32'h0C, 32'h18, 32'h1C};
    bus_wr(0, 32'h0C, 32'hffffffff);
    foreach (addrs[k]) begin
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1);
      bus_rd(0, addrs[k], d, er, rd);
      e = pop_exp(); checks++;
      if (d !== e) begin errors++; $display("FAIL unmap_rdata_%0h got %0h want %0h", addrs[k], d, e); end
      e = pop_exp(); checks++;
      if (er !== e[0]) begin errors++; $display("FAIL unmap_error_%0h got %0b want %0b", addrs[k], er, e[0]); end
      e = pop_exp(); checks++;
      if (rd !== e[0]) begin errors++; $display("FAIL unmap_ready_%0h got %0b want %0b", addrs[k], rd, e[0]); end
    end
    exp_q.push_back(3); exp_q.push_back(0);
    bus_rd(0, 32'h04, d, er, rd);
    e = pop_exp(); checks++;
    if (d !== e) begin errors++; $display("FAIL unmap_enable_kept got %0h want %0h", d, e); end
    e = pop_exp(); checks++;
    if (er !== e[0]) begin errors++; $display("FAIL mapped_error got %0b want %0b", er, e[0]); end
  endtask

  task automatic test_saturate();
    logic [31:0] d, e;
    logic er, rd;
    repeat (5) begin
      err2 = 1'b1; tick();
      err2 = 1'b0; tick();
    end
    exp_q.push_back(3);
    bus_rd(1, 32'h10, d, er, rd);
    e = pop_exp(); checks++;
    if (d !== e) begin errors++; $display("FAIL sat_count got %0d want %0d", d, e); end
    err2 = 1'b1;
    bus_wr(1, 32'h10, 32'h0);
    err2 = 1'b0;
    exp_q.push_back(1);
    bus_rd(1, 32'h10, d, er, rd);
    e = pop_exp(); checks++;
    if (d !== e) begin errors++; $display("FAIL sat_clear_edge got %0d want %0d", d, e); end
    exp_q.push_back(1);
    bus_rd(1, 32'h14, d, er, rd);
    e = pop_exp(); checks++;
    if (er !== e[0]) begin errors++; $display("FAIL sat_src1_error got %0b want %0b", er, e[0]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, e;
    logic er, rd;
    logic [31:0] addrs [5] = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14};
    bus_wr(0, 32'h10, 32'h0); cnt0 = 0;
    for (int k = 0; k < 7; k++) begin
      err_irq[0] = 1'b1; cnt0++;
      if (k == 6) begin err_irq[1] = 1'b1; cnt1++; end
      tick();
      err_irq = 2'b00;
      tick();
    end
    tick();
    exp_q.push_back(1); exp_q.push_back(7); exp_q.push_back(3);
    e = pop_exp(); checks++;
    if (irq !== e[0]) begin errors++; $display("FAIL rmid_irq_before got %0b want %0b", irq, e[0]); end
    bus_rd(0, 32'h10, d, er, rd);
    e = pop_exp(); checks++;
    if (d !== e) begin errors++; $display("FAIL rmid_count0_before got %0d want %0d", d, e); end
    bus_rd(0, 32'h00, d, er, rd);
    e = pop_exp(); checks++;
    if (d !== e) begin errors++; $display("FAIL rmid_pending_before got %0h want %0h", d, e); end
    err_irq[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(0); e = pop_exp(); checks++;
    if (irq !== e[0]) begin errors++; $display("FAIL rmid_irq_async got %0b want %0b", irq, e[0]); end
    tick();
    foreach (addrs[k]) begin
      exp_q.push_back((addrs[k] == 32'h08) ? 32'd3 : 32'd0);
      bus_rd(0, addrs[k], d, er, rd);
      e = pop_exp(); checks++;
      if (d !== e) begin errors++; $display("FAIL rmid_reg_%0h got %0h want %0h", addrs[k], d, e); end
    end
    #3 rst_n = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      exp_q.push_back(0); e = pop_exp(); checks++;
      if (irq !== e[0]) begin errors++; $display("FAIL rmid_irq_after_c%0d got %0b want %0b", c, irq, e[0]); end
      tick();
    end
    exp_q.push_back(1); exp_q.push_back(1);
    bus_rd(0, 32'h10, d, er, rd);
    e = pop_exp(); checks++;
    if (d !== e) begin errors++; $display("FAIL rmid_count0_after got %0d want %0d", d, e); end
    bus_rd(0, 32'h00, d, er, rd);
    e = pop_exp(); checks++;
    if (d !== e) begin errors++; $display("FAIL rmid_pending_after got %0h want %0h", d, e); end
    err_irq[0] = 1'b0;
  endtask

  initial begin
    err_irq = 2'b00;
    err2    = 1'b0;
    req     = '0;
    req2    = '0;
    test_reset();
    test_basic();
    test_holdoff();
    test_enable_clear();
    test_w1c_collision();
    test_count_clear();
    test_unmapped();
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
